// File: rtl/vga_layer_mixer.sv
// rtl/vga_layer_mixer.sv - VGA raster timing plus N-layer compositor with frame-latched mix mode
// Optional MIXER_SATURATE_EN: additive mix clamps per channel instead of wrapping.
module vga_layer_mixer #(
  parameter int N_LAYERS  = 3,
  parameter int COLOR_W   = 8,
  parameter int LAYER_LAT = 1,
  parameter int H_DISP    = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_DISP    = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic                            VGA_CLK,
  input  logic                            reset,
  input  logic                            mode,
  input  logic [N_LAYERS-1:0]             layer_en,
  input  logic [N_LAYERS*3*COLOR_W-1:0]   layer_rgb,
  output logic [11:0]                     CounterX,
  output logic [11:0]                     CounterY,
  output logic                            vga_h_sync,
  output logic                            vga_v_sync,
  output logic                            vga_blank,
  output logic                            vga_sync,
  output logic [COLOR_W-1:0]              vga_R,
  output logic [COLOR_W-1:0]              vga_G,
  output logic [COLOR_W-1:0]              vga_B,
  output logic                            frame_tick
);

  localparam int H_TOT  = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int SUM_W  = COLOR_W + $clog2(N_LAYERS);
  localparam int PIX_W  = 3 * COLOR_W;
  localparam int PIPE_W = 4 + N_LAYERS;
  localparam logic [PIPE_W-1:0] PIPE_RST = {1'b1, 1'b1, 1'b0, 1'b0, {N_LAYERS{1'b1}}};

  logic                frame_start;
  logic                raw_hs, raw_vs, raw_disp;
  logic                shadow_mode;
  logic [N_LAYERS-1:0] shadow_en;
  logic [PIPE_W-1:0]   stage_in, stage_out;
  logic                d_hs, d_vs, d_disp, d_mode;
  logic [N_LAYERS-1:0] d_en;
  logic [PIX_W-1:0]    layer_px [N_LAYERS];
  logic [SUM_W-1:0]    sum_r, sum_g, sum_b;
  logic [PIX_W-1:0]    pri_px, mix_px;

  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      CounterX <= '0;
      CounterY <= '0;
    end else if (CounterX == 12'(H_TOT - 1)) begin
      CounterX <= '0;
      CounterY <= (CounterY == 12'(V_TOT - 1)) ? '0 : CounterY + 12'd1;
    end else begin
      CounterX <= CounterX + 12'd1;
    end
  end

  assign frame_start = (CounterX == '0) && (CounterY == '0);
  assign raw_hs   = !((CounterX >= 12'(H_DISP + H_FP)) && (CounterX < 12'(H_DISP + H_FP + H_SYNC)));
  assign raw_vs   = !((CounterY >= 12'(V_DISP + V_FP)) && (CounterY < 12'(V_DISP + V_FP + V_SYNC)));
  assign raw_disp = (CounterX < 12'(H_DISP)) && (CounterY < 12'(V_DISP));
  assign frame_tick = !reset && (CounterX == 12'(H_TOT - 1)) && (CounterY == 12'(V_TOT - 1));
  assign vga_sync = 1'b1;

  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      shadow_mode <= 1'b0;
      shadow_en   <= '1;
    end else if (frame_start) begin
      shadow_mode <= mode;
      shadow_en   <= layer_en;
    end
  end

  // Mix controls travel with the pixel so frame boundaries switch exactly at pixel (0,0).
  assign stage_in = {raw_hs, raw_vs, raw_disp,
                     frame_start ? mode : shadow_mode,
                     frame_start ? layer_en : shadow_en};

  generate
    if (LAYER_LAT == 0) begin : g_no_pipe
      assign stage_out = stage_in;
    end else begin : g_pipe
      logic [PIPE_W-1:0] pipe [LAYER_LAT];
      always_ff @(posedge VGA_CLK) begin
        if (reset) begin
          for (int i = 0; i < LAYER_LAT; i++) pipe[i] <= PIPE_RST;
        end else begin
          pipe[0] <= stage_in;
          for (int i = 1; i < LAYER_LAT; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign stage_out = pipe[LAYER_LAT-1];
    end
  endgenerate

  assign {d_hs, d_vs, d_disp, d_mode, d_en} = stage_out;

  function automatic logic [COLOR_W-1:0] reduce_ch(input logic [SUM_W-1:0] s);
`ifdef MIXER_SATURATE_EN
    return (s > SUM_W'((1 << COLOR_W) - 1)) ? '1 : s[COLOR_W-1:0];
`else
    return s[COLOR_W-1:0];
`endif
  endfunction

  always_comb begin
    sum_r  = '0;
    sum_g  = '0;
    sum_b  = '0;
    pri_px = '0;
    for (int i = 0; i < N_LAYERS; i++) begin
      layer_px[i] = layer_rgb[i*PIX_W +: PIX_W];
      if (d_en[i]) begin
        sum_r = sum_r + SUM_W'(layer_px[i][PIX_W-1 -: COLOR_W]);
        sum_g = sum_g + SUM_W'(layer_px[i][2*COLOR_W-1 -: COLOR_W]);
        sum_b = sum_b + SUM_W'(layer_px[i][COLOR_W-1:0]);
      end
    end
    // Walk from lowest priority up so layer 0 overrides last.
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (d_en[i] && (layer_px[i] != '0)) pri_px = layer_px[i];
    end
    mix_px = d_mode ? pri_px : {reduce_ch(sum_r), reduce_ch(sum_g), reduce_ch(sum_b)};
  end

  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      vga_h_sync <= 1'b1;
      vga_v_sync <= 1'b1;
      vga_blank  <= 1'b0;
      vga_R      <= '0;
      vga_G      <= '0;
      vga_B      <= '0;
    end else begin
      vga_h_sync <= d_hs;
      vga_v_sync <= d_vs;
      vga_blank  <= d_disp;
      {vga_R, vga_G, vga_B} <= d_disp ? mix_px : '0;
    end
  end

endmodule
